// File: rtl/cp_load_sequencer.sv
// Control-plane table-load sequencer: steers host phits into the state, per-column config and
// inbound tables, then opens the kernel stream path until its last beat.
module cp_load_sequencer #(
   parameter int unsigned NUM_COL         = 6,
   parameter int unsigned ADDR_W          = 4,
   parameter int unsigned NUM_STATE_ENTRY = 2,
   parameter int unsigned START_GAP       = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_loader,
   input  logic [ADDR_W-1:0]  num_entry_config_table,
   input  logic [ADDR_W-1:0]  num_entry_inbound,
   input  logic               wr_valid,
   input  logic               stream_in_valid,
   input  logic               stream_in_last,
   output logic               wr_en_state,
   output logic [NUM_COL-1:0] wr_en_cfg,
   output logic               wr_en_inb,
   output logic [ADDR_W-1:0]  wr_add,
   output logic               load_busy,
   output logic               ready_stream_in,
   output logic               done
);

   localparam int unsigned ColW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
   localparam int unsigned GapW = $clog2(START_GAP + 1);

   typedef enum logic [2:0] {
      StIdle,
      StGap,
      StLdState,
      StLdCfg,
      StLdInb,
      StStream
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   wr_add_q, wr_add_d;
   logic [ADDR_W-1:0]   cfg_cnt_q, cfg_cnt_d;
   logic [ADDR_W-1:0]   inb_cnt_q, inb_cnt_d;
   logic [ColW-1:0]     col_q, col_d;
   logic [GapW-1:0]     gap_q, gap_d;
   logic                done_q, done_d;
   state_e              after_cfg, after_state;

   always_comb begin
      state_d         = state_q;
      wr_add_d        = wr_add_q;
      cfg_cnt_d       = cfg_cnt_q;
      inb_cnt_d       = inb_cnt_q;
      col_d           = col_q;
      gap_d           = gap_q;
      done_d          = 1'b0;
      wr_en_state     = 1'b0;
      wr_en_cfg       = '0;
      wr_en_inb       = 1'b0;
      load_busy       = 1'b0;
      ready_stream_in = 1'b0;

      // Empty tables are skipped on the same edge the preceding phase completes.
      after_cfg   = (inb_cnt_q != '0) ? StLdInb : StStream;
      after_state = (cfg_cnt_q != '0) ? StLdCfg : after_cfg;

      unique case (state_q)
         StIdle: begin
            if (start_loader) begin
               cfg_cnt_d = num_entry_config_table;
               inb_cnt_d = num_entry_inbound;
               gap_d     = '0;
               col_d     = '0;
               wr_add_d  = '0;
               state_d   = StGap;
            end
         end
         StGap: begin
            load_busy = 1'b1;
            if (gap_q == GapW'(START_GAP - 1)) begin
               state_d = StLdState;
            end else begin
               gap_d = gap_q + GapW'(1);
            end
         end
         StLdState: begin
            load_busy   = 1'b1;
            wr_en_state = wr_valid;
            if (wr_valid) begin
               if (wr_add_q == ADDR_W'(NUM_STATE_ENTRY - 1)) begin
                  wr_add_d = '0;
                  state_d  = after_state;
               end else begin
                  wr_add_d = wr_add_q + ADDR_W'(1);
               end
            end
         end
         StLdCfg: begin
            load_busy = 1'b1;
            if (wr_valid) begin
               wr_en_cfg = NUM_COL'(1) << col_q;
               if (wr_add_q == cfg_cnt_q - ADDR_W'(1)) begin
                  wr_add_d = '0;
                  if (col_q == ColW'(NUM_COL - 1)) begin
                     state_d = after_cfg;
                  end else begin
                     col_d = col_q + ColW'(1);
                  end
               end else begin
                  wr_add_d = wr_add_q + ADDR_W'(1);
               end
            end
         end
         StLdInb: begin
            load_busy = 1'b1;
            wr_en_inb = wr_valid;
            if (wr_valid) begin
               if (wr_add_q == inb_cnt_q - ADDR_W'(1)) begin
                  wr_add_d = '0;
                  state_d  = StStream;
               end else begin
                  wr_add_d = wr_add_q + ADDR_W'(1);
               end
            end
         end
         StStream: begin
            ready_stream_in = 1'b1;
            if (stream_in_valid && stream_in_last) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign wr_add = wr_add_q;
   assign done   = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         wr_add_q  <= '0;
         cfg_cnt_q <= '0;
         inb_cnt_q <= '0;
         col_q     <= '0;
         gap_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_add_q  <= wr_add_d;
         cfg_cnt_q <= cfg_cnt_d;
         inb_cnt_q <= inb_cnt_d;
         col_q     <= col_d;
         gap_q     <= gap_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_cp_load_sequencer.sv
// Bench for cp_load_sequencer: each load is modelled as the ordered list of table writes it must
// produce, consumed beat by beat against randomized valid/noise stimulus.
module tb_cp_load_sequencer;

   localparam int unsigned NUM_COL         = 6;
   localparam int unsigned ADDR_W          = 4;
   localparam int unsigned NUM_STATE_ENTRY = 2;
   localparam int unsigned START_GAP       = 2;

   typedef struct packed {
      logic               st;
      logic [NUM_COL-1:0] cfg;
      logic               inb;
      logic [ADDR_W-1:0]  addr;
   } beat_t;

   logic               clk;
   logic               rst;
   logic               start_loader;
   logic [ADDR_W-1:0]  num_entry_config_table;
   logic [ADDR_W-1:0]  num_entry_inbound;
   logic               wr_valid;
   logic               stream_in_valid;
   logic               stream_in_last;
   logic               wr_en_state;
   logic [NUM_COL-1:0] wr_en_cfg;
   logic               wr_en_inb;
   logic [ADDR_W-1:0]  wr_add;
   logic               load_busy;
   logic               ready_stream_in;
   logic               done;

   int compared   = 0;
   int mismatched = 0;

   cp_load_sequencer #(
      .NUM_COL         (NUM_COL),
      .ADDR_W          (ADDR_W),
      .NUM_STATE_ENTRY (NUM_STATE_ENTRY),
      .START_GAP       (START_GAP)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .start_loader           (start_loader),
      .num_entry_config_table (num_entry_config_table),
      .num_entry_inbound      (num_entry_inbound),
      .wr_valid               (wr_valid),
      .stream_in_valid        (stream_in_valid),
      .stream_in_last         (stream_in_last),
      .wr_en_state            (wr_en_state),
      .wr_en_cfg              (wr_en_cfg),
      .wr_en_inb              (wr_en_inb),
      .wr_add                 (wr_add),
      .load_busy              (load_busy),
      .ready_stream_in        (ready_stream_in),
      .done                   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst                    = 1'b1;
      start_loader           = 1'b1;
      wr_valid               = 1'b1;
      stream_in_valid        = 1'b1;
      stream_in_last         = 1'b1;
      num_entry_config_table = 4'd3;
      num_entry_inbound      = 4'd3;
      repeat (2) @(negedge clk);
      #1;
      compared++;
      if ({wr_en_state, wr_en_cfg, wr_en_inb, wr_add, load_busy, ready_stream_in, done} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got st=%b cfg=%b inb=%b add=%0d busy=%b rdy=%b done=%b, want all 0",
                  wr_en_state, wr_en_cfg, wr_en_inb, wr_add, load_busy, ready_stream_in, done);
      end
      @(negedge clk);
      rst          = 1'b0;
      start_loader = 1'b0;
      #1;
      compared++;
      if ({wr_en_state, wr_en_cfg, wr_en_inb, load_busy, ready_stream_in} !== '0) begin
         mismatched++;
         $display("FAIL idle_outputs: got st=%b cfg=%b inb=%b busy=%b rdy=%b, want all 0",
                  wr_en_state, wr_en_cfg, wr_en_inb, load_busy, ready_stream_in);
      end
   endtask

   // mode 0: wr_valid held high; 1: random valid plus start/stream noise; 2: 3-cycle stall in col 3.
   // abort_beat >= 0 applies reset once that many beats have been written.
   task automatic do_load(input int cfg, input int inb, input int mode, input int abort_beat,
                          input bit started);
      beat_t              q[$];
      beat_t              e;
      logic [NUM_COL-1:0] exp_cfg;
      logic [NUM_COL-1:0] col3;
      int                 taken;
      int                 cyc;
      int                 stall;
      col3 = NUM_COL'(1) << 3;
      for (int i = 0; i < int'(NUM_STATE_ENTRY); i++) q.push_back('{1'b1, '0, 1'b0, ADDR_W'(i)});
      for (int c = 0; c < int'(NUM_COL); c++)
         for (int i = 0; i < cfg; i++) q.push_back('{1'b0, NUM_COL'(1) << c, 1'b0, ADDR_W'(i)});
      for (int i = 0; i < inb; i++) q.push_back('{1'b0, '0, 1'b1, ADDR_W'(i)});

      if (!started) begin
         @(negedge clk);
         num_entry_config_table = ADDR_W'(cfg);
         num_entry_inbound      = ADDR_W'(inb);
         start_loader           = 1'b1;
         wr_valid               = 1'b1;
         stream_in_valid        = (mode != 0);
         stream_in_last         = 1'b0;
         #1;
         compared++;
         if ({load_busy, ready_stream_in} !== 2'b00) begin
            mismatched++;
            $display("FAIL start_cycle: busy=%b rdy=%b, want 0 0", load_busy, ready_stream_in);
         end
      end

      for (int g = 0; g < int'(START_GAP); g++) begin
         @(negedge clk);
         start_loader           = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         num_entry_config_table = ADDR_W'($urandom);
         num_entry_inbound      = ADDR_W'($urandom);
         wr_valid               = 1'b1;
         stream_in_valid        = 1'b1;
         stream_in_last         = 1'($urandom_range(0, 1));
         #1;
         compared++;
         if ({wr_en_state, wr_en_cfg, wr_en_inb, load_busy, ready_stream_in, done} !==
             {1'b0, {NUM_COL{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL gap_cycle%0d: st=%b cfg=%b inb=%b busy=%b rdy=%b done=%b, want 0 0 0 1 0 0",
                     g, wr_en_state, wr_en_cfg, wr_en_inb, load_busy, ready_stream_in, done);
         end
      end

      taken = 0;
      cyc   = 0;
      stall = 0;
      while (q.size() > 0) begin
         @(negedge clk);
         cyc++;
         if (cyc > 2000) begin
            compared++;
            mismatched++;
            $display("FAIL load_timeout: %0d beats left, want 0", q.size());
            break;
         end
         if (taken == abort_beat) begin
            rst             = 1'b1;
            wr_valid        = 1'b1;
            stream_in_valid = 1'b1;
            @(negedge clk);
            #1;
            compared++;
            if ({wr_en_state, wr_en_cfg, wr_en_inb, wr_add, load_busy, ready_stream_in, done} !== '0)
            begin
               mismatched++;
               $display("FAIL abort_reset: st=%b cfg=%b inb=%b add=%0d busy=%b rdy=%b done=%b, want all 0",
                        wr_en_state, wr_en_cfg, wr_en_inb, wr_add, load_busy, ready_stream_in, done);
            end
            rst = 1'b0;
            return;
         end
         e = q[0];
         case (mode)
            1:       wr_valid = 1'($urandom_range(0, 1));
            2:       wr_valid = !(e.cfg == col3 && e.addr == ADDR_W'(cfg > 1 ? 1 : 0) && stall < 3);
            default: wr_valid = 1'b1;
         endcase
         if (!wr_valid) stall++;
         start_loader           = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         stream_in_valid        = (mode != 0);
         stream_in_last         = 1'($urandom_range(0, 1));
         num_entry_config_table = ADDR_W'($urandom);
         num_entry_inbound      = ADDR_W'($urandom);
         #1;
         exp_cfg = wr_valid ? e.cfg : '0;
         compared++;
         if ({wr_en_state, wr_en_cfg, wr_en_inb} !== {e.st & wr_valid, exp_cfg, e.inb & wr_valid}) begin
            mismatched++;
            $display("FAIL strobe_beat%0d: st=%b cfg=%b inb=%b, want %b %b %b", taken,
                     wr_en_state, wr_en_cfg, wr_en_inb, e.st & wr_valid, exp_cfg, e.inb & wr_valid);
         end
         compared++;
         if (wr_add !== e.addr) begin
            mismatched++;
            $display("FAIL addr_beat%0d: wr_add=%0d, want %0d", taken, wr_add, e.addr);
         end
         compared++;
         if ({load_busy, ready_stream_in, done} !== 3'b100) begin
            mismatched++;
            $display("FAIL busy_beat%0d: busy=%b rdy=%b done=%b, want 1 0 0", taken,
                     load_busy, ready_stream_in, done);
         end
         if (wr_valid) begin
            void'(q.pop_front());
            taken++;
         end
      end
   endtask

   task automatic do_stream(input int n, input bit restart, input int ncfg, input int ninb);
      int k;
      int cyc;
      k   = 0;
      cyc = 0;
      while (k < n) begin
         @(negedge clk);
         cyc++;
         if (cyc > 500) begin
            compared++;
            mismatched++;
            $display("FAIL stream_timeout: %0d beats sent, want %0d", k, n);
            break;
         end
         stream_in_valid = ($urandom_range(0, 3) != 0);
         stream_in_last  = stream_in_valid ? (k == n - 1) : 1'($urandom_range(0, 1));
         wr_valid        = 1'($urandom_range(0, 1));
         start_loader    = 1'($urandom_range(0, 1));
         #1;
         compared++;
         if ({ready_stream_in, load_busy, done, wr_en_state, wr_en_cfg, wr_en_inb} !==
             {1'b1, 1'b0, 1'b0, 1'b0, {NUM_COL{1'b0}}, 1'b0}) begin
            mismatched++;
            $display("FAIL stream_beat%0d: rdy=%b busy=%b done=%b st=%b cfg=%b inb=%b, want 1 0 0 0 0 0",
                     k, ready_stream_in, load_busy, done, wr_en_state, wr_en_cfg, wr_en_inb);
         end
         if (stream_in_valid) k++;
      end
      @(negedge clk);
      stream_in_valid        = 1'b0;
      stream_in_last         = 1'b0;
      wr_valid               = 1'b0;
      start_loader           = restart;
      num_entry_config_table = ADDR_W'(ncfg);
      num_entry_inbound      = ADDR_W'(ninb);
      #1;
      compared++;
      if ({done, ready_stream_in, load_busy} !== 3'b100) begin
         mismatched++;
         $display("FAIL done_pulse: done=%b rdy=%b busy=%b, want 1 0 0", done, ready_stream_in, load_busy);
      end
      if (!restart) begin
         @(negedge clk);
         #1;
         compared++;
         if ({done, ready_stream_in, load_busy} !== 3'b000) begin
            mismatched++;
            $display("FAIL done_once: done=%b rdy=%b busy=%b, want 0 0 0", done, ready_stream_in, load_busy);
         end
      end
   endtask

   task automatic test_basic();
      do_load(2, 15, 0, -1, 1'b0);
      do_stream(5, 1'b0, 0, 0);
   endtask

   task automatic test_early_stream();
      do_load(3, 4, 1, -1, 1'b0);
      do_stream(2, 1'b0, 0, 0);
   endtask

   task automatic test_stall();
      do_load(2, 15, 2, -1, 1'b0);
      do_stream(1, 1'b0, 0, 0);
   endtask

   task automatic test_zero_counts();
      do_load(0, 0, 0, -1, 1'b0);
      do_stream(3, 1'b0, 0, 0);
      do_load(0, 3, 1, -1, 1'b0);
      do_stream(1, 1'b0, 0, 0);
      do_load(1, 0, 1, -1, 1'b0);
      do_stream(1, 1'b0, 0, 0);
   endtask

   task automatic test_back_to_back();
      do_load(1, 2, 0, -1, 1'b0);
      do_stream(5, 1'b1, 2, 15);
      do_load(2, 15, 0, -1, 1'b1);
      do_stream(1, 1'b0, 0, 0);
   endtask

   task automatic test_reset_mid();
      do_load(2, 15, 0, int'(NUM_STATE_ENTRY) + 2 * int'(NUM_COL) + 7, 1'b0);
      do_load(2, 15, 0, -1, 1'b0);
      do_stream(2, 1'b0, 0, 0);
   endtask

   task automatic test_random();
      for (int it = 0; it < 10; it++) begin
         do_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1, -1, 1'b0);
         do_stream(int'($urandom_range(1, 6)), 1'b0, 0, 0);
      end
   endtask

   initial begin
      rst                    = 1'b1;
      start_loader           = 1'b0;
      num_entry_config_table = '0;
      num_entry_inbound      = '0;
      wr_valid               = 1'b0;
      stream_in_valid        = 1'b0;
      stream_in_last         = 1'b0;
      test_reset();
      test_basic();
      test_early_stream();
      test_stall();
      test_zero_counts();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
